fetch_sequencer: RTL and testbench

Instruction-fetch and phase sequencer for the multicycle MIPS core. It reads the program counter's `address` and `pc_halt` outputs and issues instruction reads on the Avalon-MM instruction/data bus. It captures and byte-swaps the returned word, and generates the one-hot `fetch`/`exec1`/`exec2` phase strobes that advance the PC and the rest of the datapath. It also detects the halt condition (PC reaches 0) and stops the core.

---
 rtl/fetch_sequencer.sv | 130 +++++++++++++
 tb/tb_fetch_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Purpose: instruction fetch and FETCH/EXEC1/EXEC2 phase sequencer for the multicycle MIPS core.
// Latency: 3 cycles per instruction on a zero-wait bus; +1 FETCH per waitrequest cycle, +1 EXEC2 per data_busy cycle.
// Backpressure: avm_waitrequest holds FETCH with a stable address; data_busy holds EXEC2.
//
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   pc_address, pc_halt - current PC value and its "address == 0" flag
//   data_busy           - data-memory access in flight, extends EXEC2
//   avm_*               - Avalon-MM read master (address/read/byteenable out, waitrequest/readdata in)
//   fetch/exec1/exec2   - one-hot phase strobes driving the PC and datapath
//   instr_word          - byte-swapped instruction captured on each completed fetch
//   instr_count         - completed fetches since reset (wraps)
//   active              - core running (FETCH, EXEC1 or EXEC2)
module fetch_sequencer #(
    parameter int RESET_COUNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  pc_address,
    input  logic                         pc_halt,
    input  logic                         data_busy,
    input  logic                         avm_waitrequest,
    input  logic [31:0]                  avm_readdata,
    output logic [31:0]                  avm_address,
    output logic                         avm_read,
    output logic [3:0]                   avm_byteenable,
    output logic                         fetch,
    output logic                         exec1,
    output logic                         exec2,
    output logic [31:0]                  instr_word,
    output logic [RESET_COUNT_WIDTH-1:0] instr_count,
    output logic                         active
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC1  = 3'd2,
        ST_EXEC2  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. pc_halt is only looked at in FETCH and data_busy
    // only in EXEC2; halt takes priority over a completing read.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (pc_halt) begin
                    state_nxt = ST_HALTED;
                end else if (!avm_waitrequest) begin
                    state_nxt = ST_EXEC1;
                end
            end
            ST_EXEC1:  state_nxt = ST_EXEC2;
            ST_EXEC2: begin
                if (!data_busy) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output decode. Everything is forced low while reset is asserted so a
    // stalled read is abandoned in the same cycle reset arrives.
    always_comb begin
        avm_read       = 1'b0;
        avm_address    = 32'h0;
        avm_byteenable = 4'b0000;
        fetch          = 1'b0;
        exec1          = 1'b0;
        exec2          = 1'b0;
        active         = 1'b0;
        if (!reset) begin
            unique case (state)
                ST_FETCH: begin
                    active = 1'b1;
                    if (!pc_halt) begin
                        avm_read       = 1'b1;
                        avm_address    = pc_address;
                        avm_byteenable = 4'b1111;
                        // Strobe only when the slave accepts, so the PC holds
                        // (and the address stays put) through a stall.
                        fetch          = !avm_waitrequest;
                    end
                end
                ST_EXEC1: begin
                    active = 1'b1;
                    exec1  = 1'b1;
                end
                ST_EXEC2: begin
                    active = 1'b1;
                    exec2  = 1'b1;
                end
                default: begin
                    active = 1'b0;
                end
            endcase
        end
    end

    // Instruction capture: the bus is little-endian, the core wants the
    // word byte-reversed.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_word  <= 32'h0;
            instr_count <= '0;
        end else if (fetch) begin
            instr_word  <= {avm_readdata[7:0], avm_readdata[15:8],
                            avm_readdata[23:16], avm_readdata[31:24]};
            instr_count <= instr_count + RESET_COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_address;
    logic        pc_halt;
    logic        data_busy;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic        fetch;
    logic        exec1;
    logic        exec2;
    logic [31:0] instr_word;
    logic [31:0] instr_count;
    logic        active;

    fetch_sequencer #(.RESET_COUNT_WIDTH(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_address      (pc_address),
        .pc_halt         (pc_halt),
        .data_busy       (data_busy),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_byteenable  (avm_byteenable),
        .fetch           (fetch),
        .exec1           (exec1),
        .exec2           (exec2),
        .instr_word      (instr_word),
        .instr_count     (instr_count),
        .active          (active)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int fetch_pulses = 0;
    logic [31:0] exp_count = 0;

    // Scoreboard entry: {expected instr_word, expected instr_count} after a fetch
    logic [63:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle the strobes must be at most one-hot; after each
    // fetch pulse the captured word and count are popped and compared.
    initial begin
        logic pending;
        logic [63:0] e;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            check("strobe_onehot", 32'($countones({fetch, exec1, exec2}) <= 1), 32'd1);
            if (pending) begin
                pending = 1'b0;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_fetch", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_instr_word", instr_word, e[63:32]);
                    check("sb_instr_count", instr_count, e[31:0]);
                end
            end
            if (fetch) begin
                fetch_pulses++;
                pending = 1'b1;
            end
        end
    end

    // Precondition: called at posedge+1 of a cycle in which the DUT is in FETCH.
    task automatic do_instr(input logic [31:0] addr, input logic [31:0] rd,
                            input logic [31:0] exp_word, input int waits, input int busy);
        pc_address      = addr;
        pc_halt         = 1'b0;
        avm_readdata    = rd;
        avm_waitrequest = (waits > 0);
        exp_count       = exp_count + 1;
        sb_q.push_back({exp_word, exp_count});
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("stall_read", 32'(avm_read), 32'd1);
            check("stall_addr", avm_address, addr);
            check("stall_no_fetch", 32'(fetch), 32'd0);
            step();
            avm_waitrequest = (i + 1 < waits);
        end
        @(negedge clk);
        check("fetch_read", 32'(avm_read), 32'd1);
        check("fetch_be", 32'(avm_byteenable), 32'hF);
        check("fetch_pulse", 32'(fetch), 32'd1);
        step();
        avm_waitrequest = 1'b1;
        pc_halt         = 1'b1;          // ignored outside FETCH
        data_busy       = (busy > 0);
        @(negedge clk);
        check("exec1", {29'd0, fetch, exec1, exec2}, 32'b010);
        check("exec1_no_read", 32'(avm_read), 32'd0);
        step();
        for (int j = 0; j < busy; j++) begin
            @(negedge clk);
            check("exec2_busy", {29'd0, fetch, exec1, exec2}, 32'b001);
            step();
            if (j == busy - 1) data_busy = 1'b0;
        end
        @(negedge clk);
        check("exec2_last", {29'd0, fetch, exec1, exec2}, 32'b001);
        step();
        pc_halt = 1'b0;
    endtask

    task automatic check_idle_zero(input string name);
        @(negedge clk);
        check({name, "_outs"}, {24'd0, avm_read, avm_byteenable, fetch, exec1, exec2}, 32'd0);
        check({name, "_active"}, 32'(active), 32'd0);
        check({name, "_addr"}, avm_address, 32'd0);
        check({name, "_word"}, instr_word, 32'd0);
        check({name, "_count"}, instr_count, 32'd0);
    endtask

    // Called at posedge+1 with reset high and the DUT already in IDLE.
    // One IDLE cycle is visible with reset low, then FETCH follows.
    task automatic release_reset();
        reset = 1'b0;
        exp_count = 0;
        @(negedge clk);
        check("idle_no_read", 32'(avm_read), 32'd0);
        check("idle_inactive", 32'(active), 32'd0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [31:0] word;
        reset = 1'b1; pc_address = 32'hBFC00000; pc_halt = 1'b0; data_busy = 1'b0;
        avm_waitrequest = 1'b1; avm_readdata = 32'h0;
        step(); step();
        check_idle_zero("reset");
        step();
        release_reset();

        // Zero-wait fetch and byte swap
        do_instr(32'hBFC00000, 32'h0C000010, 32'h1000000C, 0, 0);
        // Three waitrequest cycles
        do_instr(32'hBFC00004, 32'h12345678, 32'h78563412, 3, 0);
        // data_busy for two EXEC2 cycles, then a new read
        do_instr(32'hBFC00008, 32'hAABBCCDD, 32'hDDCCBBAA, 0, 2);
        do_instr(32'hBFC0000C, 32'h01020304, 32'h04030201, 1, 1);

        // Halt: pc_halt with waitrequest low in FETCH, halt wins
        pc_address = 32'h0; pc_halt = 1'b1; avm_waitrequest = 1'b0;
        avm_readdata = 32'hDEADBEEF;
        @(negedge clk);
        check("halt_no_read", 32'(avm_read), 32'd0);
        check("halt_no_fetch", 32'(fetch), 32'd0);
        check("halt_still_active", 32'(active), 32'd1);
        step();
        for (int k = 0; k < 20; k++) begin
            pc_halt = k[0]; data_busy = k[1]; avm_waitrequest = k[2];
            @(negedge clk);
            check("halted_outs", {24'd0, avm_read, avm_byteenable, fetch, exec1, exec2, active}, 32'd0);
            check("halted_count", instr_count, 32'd4);
            check("halted_word", instr_word, 32'h04030201);
            step();
        end

        // Reset while halted
        reset = 1'b1;
        step();
        check_idle_zero("rst_halted");
        step();
        release_reset();
        do_instr(32'h00400000, 32'h11223344, 32'h44332211, 0, 0);

        // Reset during a stalled read: the in-flight data is discarded
        pc_address = 32'h00400004; avm_readdata = 32'hCAFEF00D; avm_waitrequest = 1'b1;
        @(negedge clk);
        check("pre_rst_read", 32'(avm_read), 32'd1);
        step();
        reset = 1'b1; avm_waitrequest = 1'b0;
        step();
        check_idle_zero("rst_stall");
        step();
        release_reset();

        // Ten back-to-back instructions
        base = fetch_pulses;
        for (int i = 0; i < 10; i++) begin
            word = {8'hF0, 8'h5A, 8'hA5, 8'(i)};
            do_instr(32'h00400000 + 32'(4 * i), {8'(i), 8'hA5, 8'h5A, 8'hF0}, word, i % 3, i % 2);
        end
        step(); step();
        check("b2b_count", instr_count, 32'd10);
        check("b2b_pulses", 32'(fetch_pulses - base), 32'd10);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
